// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_pkg
// Brief   : State encoding, default timing constants and helpers for sram_ctrl.
// Revision: 1.0
// ============================================================================
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W    = 18;
    localparam int DEF_RD_CYCLES = 2;
    localparam int DEF_WE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // The down-counter only ever holds (cycles - 1), so clog2 of the larger count suffices.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl
// Brief   : Single-byte req/ack controller for an external asynchronous SRAM.
// Revision: 1.0
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RD_CYCLES = DEF_RD_CYCLES,
    parameter int WE_CYCLES = DEF_WE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [7:0]        sram_data,
    output logic              sram_cs_b,
    output logic              sram_oe_b,
    output logic              sram_we_b
);

    localparam int                 c_cnt_w   = cnt_width(RD_CYCLES, WE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_rd_load = c_cnt_w'(RD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_we_load = c_cnt_w'(WE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    state_e              r_state_q, w_state_d;
    logic [c_cnt_w-1:0]  r_cnt_q,   w_cnt_d;
    logic [ADDR_W-1:0]   r_addr_q,  w_addr_d;
    logic [7:0]          r_wdata_q, w_wdata_d;
    logic [7:0]          r_rdata_q, w_rdata_d;
    logic                r_ack_q,   w_ack_d;
    logic                r_cs_b_q,  w_cs_b_d;
    logic                r_oe_b_q,  w_oe_b_d;
    logic                r_we_b_q,  w_we_b_d;
    logic                w_drive_en;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;

        case (r_state_q)
            ST_IDLE: begin
                if (req) begin
                    w_addr_d  = addr;
                    w_wdata_d = wdata;
                    if (we) begin
                        w_state_d = ST_WR_SETUP;
                    end else begin
                        w_state_d = ST_RD;
                        w_cnt_d   = c_rd_load;
                    end
                end
            end
            ST_RD: begin
                if (r_cnt_q == '0) begin
                    w_rdata_d = sram_data;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - c_one;
                end
            end
            ST_WR_SETUP: begin
                w_state_d = ST_WR_PULSE;
                w_cnt_d   = c_we_load;
            end
            ST_WR_PULSE: begin
                if (r_cnt_q == '0) begin
                    w_state_d = ST_WR_HOLD;
                end else begin
                    w_cnt_d = r_cnt_q - c_one;
                end
            end
            ST_WR_HOLD: w_state_d = ST_DONE;
            ST_DONE:    w_state_d = ST_IDLE;
            default:    w_state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight off flops.
        w_cs_b_d = !(w_state_d inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
        w_oe_b_d = (w_state_d != ST_RD);
        w_we_b_d = (w_state_d != ST_WR_PULSE);
        w_ack_d  = (w_state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
            r_ack_q   <= 1'b0;
            r_cs_b_q  <= 1'b1;
            r_oe_b_q  <= 1'b1;
            r_we_b_q  <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
            r_ack_q   <= w_ack_d;
            r_cs_b_q  <= w_cs_b_d;
            r_oe_b_q  <= w_oe_b_d;
            r_we_b_q  <= w_we_b_d;
        end
    end

    // Driving through WR_HOLD keeps the byte valid one full cycle after we_b rises.
    assign w_drive_en = (r_state_q inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
    assign sram_data  = w_drive_en ? r_wdata_q : {8{1'bz}};

    assign rdata     = r_rdata_q;
    assign ack       = r_ack_q;
    assign busy      = (r_state_q != ST_IDLE);
    assign sram_addr = r_addr_q;
    assign sram_cs_b = r_cs_b_q;
    assign sram_oe_b = r_oe_b_q;
    assign sram_we_b = r_we_b_q;

endmodule : sram_ctrl
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_sram_ctrl
// Brief   : Directed bench for sram_ctrl with behavioural async SRAM models.
// Revision: 1.0
// ============================================================================
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // Default-parameter instance
    logic        req0, we0, ack0, busy0, cs0, oe0, web0;
    logic [17:0] addr0, sram_addr0;
    logic [7:0]  wdata0, rdata0;
    wire  [7:0]  sram_data0;

    // Swept-parameter instance
    logic        req1, we1, ack1, busy1, cs1, oe1, web1;
    logic [17:0] addr1, sram_addr1;
    logic [7:0]  wdata1, rdata1;
    wire  [7:0]  sram_data1;

    logic [7:0] mem0 [0:262143];
    logic [7:0] mem1 [0:262143];

    sram_ctrl dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .busy(busy0), .sram_addr(sram_addr0),
        .sram_data(sram_data0), .sram_cs_b(cs0), .sram_oe_b(oe0), .sram_we_b(web0)
    );

    sram_ctrl #(.ADDR_W(18), .RD_CYCLES(1), .WE_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ack(ack1), .busy(busy1), .sram_addr(sram_addr1),
        .sram_data(sram_data1), .sram_cs_b(cs1), .sram_oe_b(oe1), .sram_we_b(web1)
    );

    // SRAM models: drive on CS&OE, store on the rising edge of WE while selected
    assign sram_data0 = (!cs0 && !oe0 && web0) ? mem0[sram_addr0] : 8'bzzzzzzzz;
    assign sram_data1 = (!cs1 && !oe1 && web1) ? mem1[sram_addr1] : 8'bzzzzzzzz;
    always @(posedge web0) if (!cs0) mem0[sram_addr0] <= sram_data0;
    always @(posedge web1) if (!cs1) mem1[sram_addr1] <= sram_data1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on dut0, checking strobe exclusivity and address stability each cycle.
    task automatic do_op(input logic w, input logic [17:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd);
        int n;
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        tick();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        lat = -1; rd = 8'h00; n = 1;
        while (n <= 20 && lat < 0) begin
            n_cmp++;
            if (!oe0 && !web0) begin
                n_err++;
                $display("FAIL strobe_excl: oe_b=%b we_b=%b, required not both 0", oe0, web0);
            end
            n_cmp++;
            if (!cs0 && sram_addr0 !== a) begin
                n_err++;
                $display("FAIL addr_stable: sram_addr=%h, required %h", sram_addr0, a);
            end
            if (ack0) begin
                lat = n;
                rd  = rdata0;
            end else begin
                tick();
                n++;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL op_timeout: no ack within 20 cycles, required ack");
        end
        tick();
    endtask

    task automatic test_reset();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({cs0, oe0, web0} !== 3'b111) begin
            n_err++; $display("FAIL reset_strobes: cs/oe/we=%b, required 111", {cs0, oe0, web0});
        end
        n_cmp++;
        if (sram_addr0 !== 18'h0 || rdata0 !== 8'h00) begin
            n_err++; $display("FAIL reset_regs: addr=%h rdata=%h, required 0 00", sram_addr0, rdata0);
        end
        n_cmp++;
        if (ack0 !== 1'b0 || busy0 !== 1'b0 || dut0.w_drive_en !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl: ack=%b busy=%b drv=%b, required 0 0 0", ack0, busy0, dut0.w_drive_en);
        end
        reset = 1'b0;
        tick();

        // Reset in the middle of a write pulse
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00100; wdata0 = 8'h77;
        tick();
        req0 = 1'b0;
        tick();
        n_cmp++;
        if (web0 !== 1'b0) begin
            n_err++; $display("FAIL rst_pre_pulse: we_b=%b, required 0", web0);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (web0 !== 1'b1 || cs0 !== 1'b1 || busy0 !== 1'b0 || ack0 !== 1'b0 || dut0.w_drive_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_write: we_b=%b cs_b=%b busy=%b ack=%b drv=%b, required 1 1 0 0 0",
                     web0, cs0, busy0, ack0, dut0.w_drive_en);
        end
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
                n_err++; $display("FAIL rst_no_ack: ack=%b busy=%b at cycle %0d, required 0 0", ack0, busy0, i);
            end
        end
    endtask

    task automatic test_write_read();
        logic [17:0] a;
        int          lat;
        logic [7:0]  rd;
        a = 18'h12345;
        req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = 8'h5A;
        tick();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        n_cmp++;
        if ({cs0, oe0, web0} !== 3'b011 || sram_addr0 !== a || sram_data0 !== 8'h5A) begin
            n_err++; $display("FAIL wr_setup: cs/oe/we=%b addr=%h data=%h, required 011 %h 5a",
                              {cs0, oe0, web0}, sram_addr0, sram_data0, a);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({cs0, oe0, web0} !== 3'b010 || sram_data0 !== 8'h5A || ack0 !== 1'b0) begin
                n_err++; $display("FAIL wr_pulse%0d: cs/oe/we=%b data=%h ack=%b, required 010 5a 0",
                                  i, {cs0, oe0, web0}, sram_data0, ack0);
            end
        end
        tick();
        n_cmp++;
        if ({cs0, oe0, web0} !== 3'b011 || sram_data0 !== 8'h5A || dut0.w_drive_en !== 1'b1 || ack0 !== 1'b0) begin
            n_err++; $display("FAIL wr_hold: cs/oe/we=%b data=%h drv=%b ack=%b, required 011 5a 1 0",
                              {cs0, oe0, web0}, sram_data0, dut0.w_drive_en, ack0);
        end
        tick();
        n_cmp++;
        if (ack0 !== 1'b1 || {cs0, oe0, web0} !== 3'b111 || dut0.w_drive_en !== 1'b0) begin
            n_err++; $display("FAIL wr_done: ack=%b cs/oe/we=%b drv=%b, required 1 111 0",
                              ack0, {cs0, oe0, web0}, dut0.w_drive_en);
        end
        n_cmp++;
        if (mem0[a] !== 8'h5A) begin
            n_err++; $display("FAIL wr_stored: mem=%h, required 5a", mem0[a]);
        end
        tick();

        do_op(1'b0, a, 8'h00, lat, rd);
        n_cmp++;
        if (lat !== 3 || rd !== 8'h5A) begin
            n_err++; $display("FAIL rd_5a: lat=%0d rdata=%h, required 3 5a", lat, rd);
        end
        n_cmp++;
        if (rdata0 !== 8'h5A || ack0 !== 1'b0) begin
            n_err++; $display("FAIL rd_hold: rdata=%h ack=%b, required 5a 0", rdata0, ack0);
        end
    endtask

    task automatic test_addr_edges();
        int         lat;
        logic [7:0] rd;
        do_op(1'b1, 18'h00000, 8'hA5, lat, rd);
        n_cmp++;
        if (lat !== 5) begin
            n_err++; $display("FAIL wr_lat_lo: lat=%0d, required 5", lat);
        end
        do_op(1'b1, 18'h3FFFF, 8'hC3, lat, rd);
        do_op(1'b1, 18'h00001, 8'h11, lat, rd);
        do_op(1'b0, 18'h00000, 8'h00, lat, rd);
        n_cmp++;
        if (lat !== 3 || rd !== 8'hA5) begin
            n_err++; $display("FAIL rd_addr0: lat=%0d rdata=%h, required 3 a5", lat, rd);
        end
        do_op(1'b0, 18'h3FFFF, 8'h00, lat, rd);
        n_cmp++;
        if (lat !== 3 || rd !== 8'hC3) begin
            n_err++; $display("FAIL rd_addrmax: lat=%0d rdata=%h, required 3 c3", lat, rd);
        end
    endtask

    task automatic test_ignored_req();
        int         acks;
        int         lat;
        logic [7:0] rd;
        acks = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 18'h3FFFF;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ack0) acks++;
            n_cmp++;
            if (sram_addr0 !== 18'h3FFFF || web0 !== 1'b1) begin
                n_err++; $display("FAIL ign_bus: addr=%h we_b=%b at %0d, required 3ffff 1", sram_addr0, web0, i);
            end
            if (i == 1) begin
                req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00001; wdata0 = 8'hEE;
            end else begin
                req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
            end
            tick();
        end
        n_cmp++;
        if (acks !== 1 || rdata0 !== 8'hC3) begin
            n_err++; $display("FAIL ign_acks: acks=%0d rdata=%h, required 1 c3", acks, rdata0);
        end
        do_op(1'b0, 18'h00001, 8'h00, lat, rd);
        n_cmp++;
        if (rd !== 8'h11) begin
            n_err++; $display("FAIL ign_untouched: rdata=%h, required 11", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mask;
        mask = '0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 18'h12345;
        tick();
        for (int n = 1; n <= 11; n++) begin
            mask[n] = ack0;
            if (n < 11) tick();
        end
        req0 = 1'b0;
        n_cmp++;
        if (mask !== 16'h0888 || rdata0 !== 8'h5A) begin
            n_err++; $display("FAIL b2b_acks: mask=%h rdata=%h, required 0888 5a", mask, rdata0);
        end
        tick();
    endtask

    task automatic test_random_mix();
        logic [7:0] exp_mem [0:15];
        logic       w;
        logic [3:0] idx;
        logic [7:0] d;
        int         lat;
        logic [7:0] rd;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 8'(i * 17 + 3);
            do_op(1'b1, 18'h20000 + 18'(i), exp_mem[i], lat, rd);
        end
        for (int k = 0; k < 1000; k++) begin
            w   = 1'($urandom_range(0, 1));
            idx = 4'($urandom_range(0, 15));
            d   = 8'($urandom_range(0, 255));
            do_op(w, 18'h20000 + 18'(idx), d, lat, rd);
            n_cmp++;
            if (lat !== (w ? 5 : 3)) begin
                n_err++; $display("FAIL mix_lat: op %0d we=%b lat=%0d", k, w, lat);
            end
            if (w) begin
                exp_mem[idx] = d;
            end else begin
                n_cmp++;
                if (rd !== exp_mem[idx]) begin
                    n_err++; $display("FAIL mix_rdata: op %0d addr %h rdata=%h, required %h", k, idx, rd, exp_mem[idx]);
                end
            end
        end
    endtask

    task automatic test_param_sweep();
        int lat;
        int low;
        lat = -1; low = 0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 18'h00ABC; wdata1 = 8'h3C;
        tick();
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            n_cmp++;
            if (!oe1 && !web1) begin
                n_err++; $display("FAIL sw_excl: oe_b=%b we_b=%b", oe1, web1);
            end
            if (!web1) low++;
            if (ack1) lat = n;
            else tick();
        end
        n_cmp++;
        if (lat !== 7 || low !== 4) begin
            n_err++; $display("FAIL sw_write: ack_lat=%0d we_low=%0d, required 7 4", lat, low);
        end
        tick();
        lat = -1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00ABC;
        tick();
        req1 = 1'b0; addr1 = '0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            if (ack1) lat = n;
            else tick();
        end
        n_cmp++;
        if (lat !== 2 || rdata1 !== 8'h3C) begin
            n_err++; $display("FAIL sw_read: ack_lat=%0d rdata=%h, required 2 3c", lat, rdata1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_edges();
        test_ignored_req();
        test_back_to_back();
        test_random_mix();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sram_ctrl
`default_nettype wire
